// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared state enum, skid depth and burst length clamp for the burst drain controller
package fifo_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ARM, BURST, FLUSH, DRAIN} state_e;
  localparam int SKID_DEPTH = 2;
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input int unsigned max_burst);
    return (len == 32'd0) ? 32'd1 : (len > max_burst) ? 32'(max_burst) : len;
  endfunction
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry {last,data} buffer with bypass; push on read return, pop on valid&&ready; ports clk/reset, push side, stream side, count
module fifo_rd_skid import fifo_ctrl_pkg::*; #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         push_last,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic         valid,
  output logic         last,
  output logic [W-1:0] data,
  output logic [1:0]   count
);
  logic [W:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic pop, pop_st, push_st, wp;
  always_comb begin
    valid = (cnt_q != 2'd0) || push;
    {last, data} = (cnt_q != 2'd0) ? e0_q : push ? {push_last, push_data} : '0;
    pop = valid && ready;
    pop_st = pop && (cnt_q != 2'd0);
    push_st = push && !(pop && cnt_q == 2'd0);
    wp = (cnt_q - {1'b0, pop_st}) != 2'd0;
    e0_d = (push_st && !wp) ? {push_last, push_data} : pop_st ? e1_q : e0_q;
    e1_d = (push_st && wp) ? {push_last, push_data} : e1_q;
    cnt_d = cnt_q + {1'b0, push_st} - {1'b0, pop_st};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
    end
  assign count = cnt_q;
endmodule

// File: rtl/fifo_burst_drain_ctrl.sv
// fifo_burst_drain_ctrl: drains fixed-length bursts (or a flushed remainder) from a 1-cycle-latency FIFO onto a valid/ready stream with m_last
module fifo_burst_drain_ctrl import fifo_ctrl_pkg::*; #(
  parameter int pDATA_WIDTH = 8,
  parameter int pDEPTH      = 32,
  parameter int pMAX_BURST  = 16,
  parameter int pCNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [pCNT_WIDTH-1:0]  burst_len,
  output logic [31:0]            fifo_full_threshold_value,
  input  logic                   fifo_full_threshold,
  input  logic                   fifo_empty,
  input  logic                   fifo_almost_empty,
  input  logic                   fifo_overflow,
  input  logic                   fifo_underflow,
  output logic                   fifo_ren,
  input  logic [pDATA_WIDTH-1:0] fifo_rdata,
  output logic [pDATA_WIDTH-1:0] m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic                   busy,
  output logic [pCNT_WIDTH-1:0]  burst_count,
  output logic                   error_flag,
  input  logic                   error_clear
);
  if (pMAX_BURST >= pDEPTH) begin : g_bad_cfg
    $error("pMAX_BURST must be below pDEPTH");
  end
  state_e state_q, state_d;
  logic [pCNT_WIDTH-1:0] rem_q, rem_d, burst_count_q, burst_count_d;
  logic inflight_q, inflight_last_q, flush_pend_q, flush_pend_d, error_q, error_d;
  logic [1:0] skid_count;
  logic pop, reading, last_rd, go_burst, go_flush;
  assign fifo_full_threshold_value = clamp_len(32'(burst_len), pMAX_BURST);
  always_comb begin
    pop = m_valid && m_ready;
    reading = (state_q == BURST) || (state_q == FLUSH);
    fifo_ren = reading && !fifo_empty && (3'(skid_count) + 3'(inflight_q) - 3'(pop) < 3'(SKID_DEPTH));
    last_rd = fifo_ren && (rem_q == pCNT_WIDTH'(1) || (state_q == FLUSH && fifo_almost_empty));
    go_burst = (state_q == ARM) && fifo_full_threshold && enable;
    go_flush = (state_q == ARM) && !go_burst && (flush || flush_pend_q) && !fifo_empty;
    state_d = (state_q == IDLE) ? (enable ? ARM : IDLE)
            : (state_q == ARM) ? (go_burst ? BURST : go_flush ? FLUSH : enable ? ARM : IDLE)
            : reading ? (last_rd ? DRAIN : state_q)
            : (state_q == DRAIN) ? ((pop && m_last) ? (enable ? ARM : IDLE) : DRAIN)
            : IDLE;
    rem_d = (go_burst || go_flush) ? fifo_full_threshold_value[pCNT_WIDTH-1:0]
          : fifo_ren ? rem_q - pCNT_WIDTH'(1) : rem_q;
    // a flush seen in ARM is consumed unless a threshold burst takes priority
    flush_pend_d = (state_q == ARM && !go_burst) ? 1'b0 : (flush_pend_q || flush);
    burst_count_d = burst_count_q + pCNT_WIDTH'(pop && m_last);
    error_d = fifo_overflow || fifo_underflow || (error_q && !error_clear);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      rem_q <= '0;
      inflight_q <= 1'b0;
      inflight_last_q <= 1'b0;
      flush_pend_q <= 1'b0;
      burst_count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      inflight_q <= fifo_ren;
      inflight_last_q <= last_rd;
      flush_pend_q <= flush_pend_d;
      burst_count_q <= burst_count_d;
      error_q <= error_d;
    end
  fifo_rd_skid #(.W(pDATA_WIDTH)) u_skid (
    .clk(clk),
    .reset(reset),
    .push(inflight_q),
    .push_last(inflight_last_q),
    .push_data(fifo_rdata),
    .ready(m_ready),
    .valid(m_valid),
    .last(m_last),
    .data(m_data),
    .count(skid_count)
  );
  assign busy = (state_q != IDLE) || m_valid;
  assign burst_count = burst_count_q;
  assign error_flag = error_q;
endmodule

// File: tb/tb_fifo_burst_drain_ctrl.sv
// tb_fifo_burst_drain_ctrl: directed and randomized bursts against a queue-based FIFO and stream scoreboard
module tb_fifo_burst_drain_ctrl;
  localparam int DW = 8, DEPTH = 32, MAXB = 16, CW = 16;
  logic clk = 0, reset = 1, enable = 0, flush = 0, m_ready = 1, error_clear = 0;
  logic fifo_full_threshold, fifo_empty, fifo_almost_empty, fifo_overflow, fifo_underflow;
  logic fifo_ren, m_valid, m_last, busy, error_flag;
  logic [CW-1:0] burst_len = 0, burst_count;
  logic [31:0] thr;
  logic [DW-1:0] fifo_rdata, m_data;
  logic wr_en = 0, inj_ovf = 0, ovf_q, unf_q;
  logic [DW-1:0] wr_data = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW:0] got[$];
  logic [DW:0] stall_v;
  logic stall_q = 0;
  int fcnt = 0, checks = 0, errors = 0, ren_cnt = 0, bursts_exp = 0;
  always #5 clk = ~clk;
  always @(posedge clk or posedge reset)
    if (reset) begin
      fq.delete();
      fcnt <= 0;
      fifo_rdata <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= wr_en && fq.size() >= DEPTH;
      unf_q <= fifo_ren && fq.size() == 0;
      if (fifo_ren && fq.size() != 0) fifo_rdata <= fq.pop_front();
      if (wr_en && fq.size() < DEPTH) fq.push_back(wr_data);
      fcnt <= fq.size();
    end
  assign fifo_empty = fcnt == 0;
  assign fifo_almost_empty = fcnt <= 1;
  assign fifo_full_threshold = 32'(fcnt) >= thr;
  assign fifo_overflow = ovf_q || inj_ovf;
  assign fifo_underflow = unf_q;
  fifo_burst_drain_ctrl #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pMAX_BURST(MAXB), .pCNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .burst_len(burst_len),
    .fifo_full_threshold_value(thr), .fifo_full_threshold(fifo_full_threshold),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow), .fifo_ren(fifo_ren),
    .fifo_rdata(fifo_rdata), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .burst_count(burst_count), .error_flag(error_flag),
    .error_clear(error_clear)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (reset) stall_q = 1'b0;
    else begin
      if (stall_q) chk("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, stall_v}));
      if (fifo_ren) begin
        ren_cnt++;
        chk("ren_nonempty", 32'(fifo_empty), 32'(0));
      end
      if (m_valid && m_ready) got.push_back({m_last, m_data});
      stall_q = m_valid && !m_ready;
      stall_v = {m_last, m_data};
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic write_words(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      wr_en = 1;
      wr_data = DW'($urandom);
      exp_q.push_back(wr_data);
      tick();
      wr_en = 0;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask
  task automatic set_ready(input int mode);
    m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~m_ready : 1'($urandom_range(0, 1));
  endtask
  task automatic drain_check(input string tag, input int total, input int blen, input int mode);
    int waited = 0;
    do begin
      set_ready(mode);
      tick();
      waited++;
    end while (got.size() < total && waited < 600);
    m_ready = 1;
    chk({tag, "_beats"}, 32'(got.size()), 32'(total));
    for (int i = 0; i < total && got.size() > 0; i++) begin
      logic [DW:0] b;
      logic [DW-1:0] e;
      b = got.pop_front();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      chk({tag, "_data"}, 32'(b[DW-1:0]), 32'(e));
      chk({tag, "_last"}, 32'(b[DW]), 32'(i % blen == blen - 1));
    end
    bursts_exp += total / blen;
    chk({tag, "_count"}, 32'(burst_count), 32'(bursts_exp[CW-1:0]));
  endtask
  initial begin
    int w, r0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_ren", 32'(fifo_ren), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(burst_count), 0);
    chk("rst_err", 32'(error_flag), 0);
    chk("thr_len0", thr, 1);
    tick();
    reset = 0;
    burst_len = 4;
    enable = 1;
    repeat (3) tick();
    write_words(4, 0);
    @(negedge clk);
    chk("lat_n_ren", 32'(fifo_ren), 0);
    chk("lat_n_valid", 32'(m_valid), 0);
    tick();
    @(negedge clk);
    chk("lat_n1_ren", 32'(fifo_ren), 1);
    chk("lat_n1_valid", 32'(m_valid), 0);
    tick();
    @(negedge clk);
    chk("lat_n2_valid", 32'(m_valid), 1);
    drain_check("t1", 4, 4, 0);
    enable = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("t1_busy_idle", 32'(busy), 0);
    enable = 1;
    tick();
    burst_len = 8;
    write_words(8, 1);
    drain_check("t2", 8, 8, 1);
    chk("t2_err", 32'(error_flag), 0);
    write_words(3, 0);
    repeat (2) tick();
    flush = 1;
    tick();
    flush = 0;
    drain_check("t3", 3, 3, 0);
    repeat (2) tick();
    @(negedge clk);
    chk("t3_empty", 32'(fifo_empty), 1);
    chk("t3_busy_arm", 32'(busy), 1);
    burst_len = 0;
    tick();
    @(negedge clk);
    chk("thr_len0_b", thr, 1);
    write_words(1, 0);
    drain_check("t4a", 1, 1, 0);
    burst_len = 100;
    tick();
    @(negedge clk);
    chk("thr_len100", thr, 16);
    write_words(16, 1);
    drain_check("t4b", 16, 16, 2);
    burst_len = 4;
    write_words(4, 0);
    w = 0;
    while (got.size() < 2 && w < 100) begin
      tick();
      w++;
    end
    enable = 0;
    drain_check("t5", 4, 4, 0);
    repeat (3) tick();
    r0 = ren_cnt;
    write_words(4, 0);
    repeat (20) tick();
    @(negedge clk);
    chk("t5_no_reads", 32'(ren_cnt), 32'(r0));
    chk("t5_busy", 32'(busy), 0);
    chk("t5_valid", 32'(m_valid), 0);
    enable = 1;
    drain_check("t5_resume", 4, 4, 0);
    for (int k = 0; k < 6; k++) begin
      int l;
      l = $urandom_range(1, MAXB);
      burst_len = CW'(l);
      write_words(l, 1);
      drain_check("rnd", l, l, 2);
    end
    burst_len = 8;
    write_words(8, 0);
    w = 0;
    while (got.size() < 2 && w < 100) begin
      tick();
      w++;
    end
    reset = 1;
    #1;
    chk("t6_valid", 32'(m_valid), 0);
    chk("t6_last", 32'(m_last), 0);
    chk("t6_data", 32'(m_data), 0);
    chk("t6_ren", 32'(fifo_ren), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_count", 32'(burst_count), 0);
    got.delete();
    exp_q.delete();
    bursts_exp = 0;
    tick();
    reset = 0;
    repeat (10) tick();
    chk("t6_no_beats", 32'(got.size()), 0);
    chk("t6_count_after", 32'(burst_count), 0);
    inj_ovf = 1;
    error_clear = 1;
    tick();
    inj_ovf = 0;
    error_clear = 0;
    @(negedge clk);
    chk("err_set_wins", 32'(error_flag), 1);
    tick();
    @(negedge clk);
    chk("err_sticky", 32'(error_flag), 1);
    error_clear = 1;
    tick();
    error_clear = 0;
    @(negedge clk);
    chk("err_cleared", 32'(error_flag), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
